// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the scoreboarded register file:
//   - default DATA_WIDTH / ADDR_WIDTH constants
//   - write_port_t bundle {en, addr, data} sized with the defaults
//   - alias_addr(): the all-ones address that aliases the program counter
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } write_port_t;

    // The highest address of a 2**addr_width register space.
    function automatic int unsigned alias_addr(input int unsigned addr_width);
        return (32'd1 << addr_width) - 32'd1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per register, tracking loads that have been issued but not
// yet written back.
//   clock, reset_n            : clock, asynchronous active-low reset
//   reserve_en, reserve_addr  : load issued -> set busy at the edge
//   clear_en, clear_addr      : load writeback -> clear busy at the edge
//   read_addr                 : packed read addresses (NUM_READ ports)
//   read_busy                 : busy flag per read port
//   hazard_error              : sticky, reserve hit an already-busy register
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int NUM_READ   = 3,
    parameter int PC_ALIAS   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         reserve_en,
    input  logic [ADDR_WIDTH-1:0]        reserve_addr,
    input  logic                         clear_en,
    input  logic [ADDR_WIDTH-1:0]        clear_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ-1:0]          read_busy,
    output logic                         hazard_error
);

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam int unsigned ALIAS_INT = alias_addr(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIAS = ALIAS_INT[ADDR_WIDTH-1:0];
    localparam bit          ALIAS_ON  = (PC_ALIAS != 0);
    localparam bit          BYPASS_ON = (BYPASS != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             reserve_valid;
    logic             hazard_set;

    // Reserves to the PC alias never reach the scoreboard, so that register
    // can never look busy or raise a hazard.
    assign reserve_valid = reserve_en && !(ALIAS_ON && (reserve_addr == ALIAS));

    // A reserve only conflicts if the register stays busy through this edge;
    // a writeback landing in the same cycle frees it first.
    assign hazard_set = reserve_valid && busy[reserve_addr]
                        && !(clear_en && (clear_addr == reserve_addr));

    // Clear first, then set, so a same-cycle reserve wins over the writeback.
    always_comb begin
        busy_next = busy;
        if (clear_en) begin
            busy_next[clear_addr] = 1'b0;
        end
        if (reserve_valid) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= '0;
            hazard_error <= 1'b0;
        end else begin
            busy <= busy_next;
            if (hazard_set) begin
                hazard_error <= 1'b1;
            end
        end
    end

    // With bypass, a writeback in flight already reads as not busy unless a
    // new load is being issued to the same register in the same cycle.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        read_busy = '0;
        ra        = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (ALIAS_ON && (ra == ALIAS)) begin
                read_busy[p] = 1'b0;
            end else if (BYPASS_ON && clear_en && (clear_addr == ra)
                         && !(reserve_valid && (reserve_addr == ra))) begin
                read_busy[p] = 1'b0;
            end else begin
                read_busy[p] = busy[ra];
            end
        end
    end

endmodule

// File: rtl/register_file_scoreboarded.sv
// ----------------------------------------------------------------------------
// register_file_scoreboarded
// Parametrised register file with two prioritised write ports, optional
// same-cycle bypass, a program-counter alias at the top address and a busy
// scoreboard for outstanding loads.
//   clock, reset_n             : clock, asynchronous active-low reset
//   read_addr / read_data      : NUM_READ packed combinational read ports
//   read_busy                  : busy flag per read port
//   program_counter            : value returned at the alias address
//   w0_en/w0_addr/w0_data      : ALU writeback (wins on address collision)
//   w1_en/w1_addr/w1_data      : load writeback, also clears busy
//   reserve_en/reserve_addr    : load issued, marks register busy
//   hazard_error               : sticky double-reserve indication
// ----------------------------------------------------------------------------
module register_file_scoreboarded
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int NUM_READ   = 3,
    parameter int PC_ALIAS   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_busy,
    input  logic [DATA_WIDTH-1:0]          program_counter,
    input  logic                           w0_en,
    input  logic [ADDR_WIDTH-1:0]          w0_addr,
    input  logic [DATA_WIDTH-1:0]          w0_data,
    input  logic                           w1_en,
    input  logic [ADDR_WIDTH-1:0]          w1_addr,
    input  logic [DATA_WIDTH-1:0]          w1_data,
    input  logic                           reserve_en,
    input  logic [ADDR_WIDTH-1:0]          reserve_addr,
    output logic                           hazard_error
);

    localparam int          DEPTH       = 2 ** ADDR_WIDTH;
    localparam int unsigned ALIAS_INT   = alias_addr(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIAS = ALIAS_INT[ADDR_WIDTH-1:0];
    localparam bit          ALIAS_ON    = (PC_ALIAS != 0);
    localparam bit          BYPASS_ON   = (BYPASS != 0);
    localparam int          STORE_DEPTH = ALIAS_ON ? DEPTH - 1 : DEPTH;

    logic [DATA_WIDTH-1:0] regs [STORE_DEPTH];
    logic                  w0_valid;
    logic                  w1_valid;

    // Writes to the PC alias are discarded; there is no storage behind it.
    assign w0_valid = w0_en && !(ALIAS_ON && (w0_addr == ALIAS));
    assign w1_valid = w1_en && !(ALIAS_ON && (w1_addr == ALIAS));

    // w0 is assigned last so it overrides w1 when both hit the same register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STORE_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (w1_valid) begin
                regs[w1_addr] <= w1_data;
            end
            if (w0_valid) begin
                regs[w0_addr] <= w0_data;
            end
        end
    end

    // Read mux: alias first, then bypass in write-port priority order,
    // then storage.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        read_data = '0;
        ra        = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (ALIAS_ON && (ra == ALIAS)) begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = program_counter;
            end else if (BYPASS_ON && w0_en && (w0_addr == ra)) begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = w0_data;
            end else if (BYPASS_ON && w1_en && (w1_addr == ra)) begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = w1_data;
            end else begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
            end
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .PC_ALIAS   (PC_ALIAS),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clock        (clock),
        .reset_n      (reset_n),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .clear_en     (w1_en),
        .clear_addr   (w1_addr),
        .read_addr    (read_addr),
        .read_busy    (read_busy),
        .hazard_error (hazard_error)
    );

endmodule
